// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl -- Z80 I/O-bus interrupt controller sitting beside the T80.
// Latches asynchronous event inputs as pending interrupts, drives INT_n, and
// answers IM2 acknowledge cycles with a vector {vbase[7:3], idx[1:0], 1'b0}.
//
// Registers (offset from BASE, decoded on addr[7:0]):
//   +0 status  read pending, write-1-to-clear
//   +1 enable  R/W, bits [NSRC-1:0]
//   +2 vbase   R/W, bits [7:3] stored, [2:0] read 0
//   +3 mode    R/W level-sensitive select when IRQ_LEVEL_EN is defined,
//              otherwise reads 8'h00 and ignores writes
//
// Ports:
//   cpu_clk           CPU clock, all logic on rising edge
//   reset_n           asynchronous active-low reset
//   irq_in[NSRC-1:0]  raw event inputs, any clock domain
//   iorq_n, m1_n, rd_n, wr_n, addr[7:0], din[7:0]  Z80 bus
//   dout[7:0]         register read data or IM2 vector
//   dout_oe           high while dout must drive the CPU data bus
//   int_n             registered interrupt request to the T80
//
// Build option: `define IRQ_LEVEL_EN enables the mode register.
module z80_irq_ctrl #(
  parameter int unsigned NSRC = 4,
  parameter logic [7:0]  BASE = 8'h10
) (
  input  logic            cpu_clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_in,
  input  logic            iorq_n,
  input  logic            m1_n,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic [7:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            dout_oe,
  output logic            int_n
);

  typedef enum logic {IDLE, ACK} ack_state_t;

  ack_state_t      state, state_next;
  logic [NSRC-1:0] sync1, sync2, sync3;
  logic [NSRC-1:0] pending, pending_next, enable;
  logic [NSRC-1:0] rise, clr, level_mask, masked;
  logic [4:0]      vbase;
  logic [1:0]      ack_idx, sel_idx;
  logic            spurious, sel_none;
  logic            io_wr, io_rd, io_wr_d, wr_pulse, addr_hit, ack_cycle;
  logic [7:0]      off, reg_rd;

`ifdef IRQ_LEVEL_EN
  logic [NSRC-1:0] mode;
  assign level_mask = mode;
`else
  assign level_mask = '0;
`endif

  // Offset arithmetic lets BASE sit on any byte boundary.
  assign off       = addr - BASE;
  assign addr_hit  = (off[7:2] == 6'd0);
  assign ack_cycle = !m1_n && !iorq_n;
  assign io_wr     = !iorq_n && !wr_n && m1_n && addr_hit && (state == IDLE);
  assign io_rd     = !iorq_n && !rd_n && m1_n && addr_hit && (state == IDLE);
  assign wr_pulse  = io_wr && !io_wr_d;
  assign rise      = sync2 & ~sync3;
  assign masked    = pending & enable;

  always_comb begin
    sel_idx  = '0;
    sel_none = 1'b1;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (masked[i] && sel_none) begin
        sel_idx  = 2'(i);
        sel_none = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    clr        = '0;
    if (wr_pulse && off[1:0] == 2'd0) clr = din[NSRC-1:0];
    case (state)
      IDLE: if (ack_cycle) state_next = ACK;
      ACK: begin
        if (iorq_n) begin
          state_next = IDLE;
          if (!spurious) begin
            for (int unsigned i = 0; i < NSRC; i++)
              if (ack_idx == 2'(i)) clr[i] = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // New edge beats a same-cycle clear; level bits ignore clears entirely.
    pending_next = (pending & ~clr) | rise;
    pending_next = (pending_next & ~level_mask) | (sync2 & level_mask);
  end

  always_comb begin
    reg_rd = '0;
    case (off[1:0])
      2'd0: reg_rd[NSRC-1:0] = pending;
      2'd1: reg_rd[NSRC-1:0] = enable;
      2'd2: reg_rd = {vbase, 3'b000};
`ifdef IRQ_LEVEL_EN
      2'd3: reg_rd[NSRC-1:0] = mode;
`endif
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    dout_oe = 1'b0;
    dout    = '0;
    if (state == ACK) begin
      // Vector drive ends combinationally as soon as IORQ_n rises.
      dout_oe = !iorq_n;
      if (!iorq_n) dout = {vbase, ack_idx, 1'b0};
    end else if (io_rd) begin
      dout_oe = 1'b1;
      dout    = reg_rd;
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      pending  <= '0;
      enable   <= '0;
      vbase    <= '0;
      ack_idx  <= '0;
      spurious <= 1'b0;
      io_wr_d  <= 1'b0;
      int_n    <= 1'b1;
    end else begin
      state   <= state_next;
      sync1   <= irq_in;
      sync2   <= sync1;
      sync3   <= sync2;
      io_wr_d <= io_wr;
      pending <= pending_next;
      int_n   <= ~|masked;
      if (state == IDLE && ack_cycle) begin
        ack_idx  <= sel_idx;
        spurious <= sel_none;
      end
      if (wr_pulse && off[1:0] == 2'd1) enable <= din[NSRC-1:0];
      if (wr_pulse && off[1:0] == 2'd2) vbase  <= din[7:3];
    end
  end

`ifdef IRQ_LEVEL_EN
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n)                           mode <= '0;
    else if (wr_pulse && off[1:0] == 2'd3) mode <= din[NSRC-1:0];
  end
`endif

endmodule

// File: tb/tb_z80_irq_ctrl.sv
module tb_z80_irq_ctrl;

  localparam logic [7:0] BASE = 8'h10;

  logic       cpu_clk, reset_n;
  logic [3:0] irq_in;
  logic       iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] addr, din, dout;
  logic       dout_oe, int_n;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  z80_irq_ctrl #(.NSRC(4), .BASE(BASE)) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .irq_in(irq_in),
    .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout(dout), .dout_oe(dout_oe), .int_n(int_n)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int cycles);
    @(negedge cpu_clk);
    addr = a; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (cycles) @(negedge cpu_clk);
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic o);
    @(negedge cpu_clk);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = dout; o = dout_oe;
    @(posedge cpu_clk);
    #1;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wait_int_low(input string tag);
    int n = 0;
    while (int_n !== 1'b0 && n < 8) begin @(negedge cpu_clk); n++; end
    vectors++;
    if (int_n !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: int_n=%b after %0d cycles, required 0", tag, int_n, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, e; logic o;
    repeat (3) @(negedge cpu_clk);
    vectors++;
    if (int_n !== 1'b1 || dout_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: int_n=%b dout_oe=%b, required 1/0", int_n, dout_oe);
    end
    @(negedge cpu_clk); reset_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      io_read(BASE + 8'(i), d, o);
      e = exp_q.pop_front(); vectors++;
      if (d !== e || o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h oe=%b, required %h oe=1", i, d, o, e);
      end
    end
  endtask

  task automatic test_edge_latch();
    logic [7:0] d, e; logic o;
    io_write(BASE + 8'd1, 8'h01, 1);
    @(negedge cpu_clk); irq_in[0] = 1'b1;
    repeat (2) @(negedge cpu_clk); irq_in[0] = 1'b0;
    wait_int_low("edge_int");
    exp_q.push_back(8'h01);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL edge_status: got %h, required %h", d, e); end
    io_write(BASE, 8'h01, 1);
    repeat (2) @(negedge cpu_clk);
    vectors++;
    if (int_n !== 1'b1) begin miscompares++; $display("FAIL edge_w1c_int: int_n=%b, required 1", int_n); end
    exp_q.push_back(8'h00);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL edge_w1c_status: got %h, required %h", d, e); end
  endtask

  task automatic test_ack_priority();
    logic [7:0] d, e; logic o;
    logic [7:0] vec[3];
    logic [7:0] after[3];
    vec[0] = 8'hA2; vec[1] = 8'hA6; vec[2] = 8'hA0;   // third ack is spurious
    after[0] = 8'h08; after[1] = 8'h00; after[2] = 8'h00;
    io_write(BASE + 8'd2, 8'hA5, 1);                   // low bits must be dropped
    io_write(BASE + 8'd1, 8'h0F, 1);
    exp_q.push_back(8'hA0);
    io_read(BASE + 8'd2, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL vbase_read: got %h, required %h", d, e); end
    @(negedge cpu_clk); irq_in[1] = 1'b1; irq_in[3] = 1'b1;
    repeat (2) @(negedge cpu_clk); irq_in[1] = 1'b0; irq_in[3] = 1'b0;
    wait_int_low("ack_int");
    for (int unsigned k = 0; k < 3; k++) begin
      exp_q.push_back(vec[k]);
      @(negedge cpu_clk); m1_n = 1'b0; iorq_n = 1'b0;
      @(negedge cpu_clk);
      e = exp_q.pop_front(); vectors++;
      if (dout !== e || dout_oe !== 1'b1) begin
        miscompares++;
        $display("FAIL ack%0d_vector: got %h oe=%b, required %h oe=1", k, dout, dout_oe, e);
      end
      m1_n = 1'b1; iorq_n = 1'b1;
      #1; vectors++;
      if (dout_oe !== 1'b0) begin miscompares++; $display("FAIL ack%0d_release: dout_oe=%b, required 0", k, dout_oe); end
      exp_q.push_back(after[k]);
      io_read(BASE, d, o);
      e = exp_q.pop_front(); vectors++;
      if (d !== e) begin miscompares++; $display("FAIL ack%0d_pending: got %h, required %h", k, d, e); end
    end
    repeat (2) @(negedge cpu_clk);
    vectors++;
    if (int_n !== 1'b1) begin miscompares++; $display("FAIL ack_int_release: int_n=%b, required 1", int_n); end
  endtask

  task automatic test_mask_collision();
    logic [7:0] d, e; logic o;
    io_write(BASE + 8'd1, 8'h00, 1);
    @(negedge cpu_clk); irq_in[2] = 1'b1;
    repeat (2) @(negedge cpu_clk); irq_in[2] = 1'b0;
    repeat (5) @(negedge cpu_clk);
    vectors++;
    if (int_n !== 1'b1) begin miscompares++; $display("FAIL mask_int: int_n=%b, required 1", int_n); end
    exp_q.push_back(8'h04);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL mask_status: got %h, required %h", d, e); end
    repeat (4) @(negedge cpu_clk);
    // W1C strobe lands on the same clock as the new edge sets the bit.
    @(negedge cpu_clk); irq_in[2] = 1'b1;
    @(negedge cpu_clk);
    io_write(BASE, 8'h04, 1);
    irq_in[2] = 1'b0;
    exp_q.push_back(8'h04);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL collision_status: got %h, required %h", d, e); end
    repeat (4) @(negedge cpu_clk);
  endtask

  task automatic test_write_once();
    logic [7:0] d, e; logic o;
    // Held W1C: the first strobe clears the old bit; an edge landing later
    // in the hold must survive because the held cycles are not new writes.
    @(negedge cpu_clk);
    irq_in[2] = 1'b1; addr = BASE; din = 8'h04; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(negedge cpu_clk);
    iorq_n = 1'b1; wr_n = 1'b1; irq_in[2] = 1'b0;
    exp_q.push_back(8'h04);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL held_w1c_status: got %h, required %h", d, e); end
    io_write(BASE + 8'd1, 8'h03, 3);
    exp_q.push_back(8'h03);
    io_read(BASE + 8'd1, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL held_enable: got %h, required %h", d, e); end
    io_read(BASE + 8'd5, d, o);
    vectors++;
    if (o !== 1'b0) begin miscompares++; $display("FAIL unmapped_oe: dout_oe=%b, required 0", o); end
    io_write(BASE + 8'd1, 8'h00, 1);
    io_write(BASE, 8'hFF, 1);
    repeat (4) @(negedge cpu_clk);
  endtask

  task automatic test_mode();
    logic [7:0] d, e; logic o;
`ifdef IRQ_LEVEL_EN
    io_write(BASE + 8'd3, 8'h01, 1);
    exp_q.push_back(8'h01);
    io_read(BASE + 8'd3, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL mode_read: got %h, required %h", d, e); end
    @(negedge cpu_clk); irq_in[0] = 1'b1;
    repeat (4) @(negedge cpu_clk);
    io_write(BASE, 8'h01, 1);
    exp_q.push_back(8'h01);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL level_w1c: got %h, required %h", d, e); end
    @(negedge cpu_clk); irq_in[0] = 1'b0;
    repeat (3) @(negedge cpu_clk);
    exp_q.push_back(8'h00);
    io_read(BASE, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e) begin miscompares++; $display("FAIL level_drop: got %h, required %h", d, e); end
    io_write(BASE + 8'd3, 8'h00, 1);
`else
    io_write(BASE + 8'd3, 8'hFF, 1);
    exp_q.push_back(8'h00);
    io_read(BASE + 8'd3, d, o);
    e = exp_q.pop_front(); vectors++;
    if (d !== e || o !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_absent: got %h oe=%b, required %h oe=1", d, o, e);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, e; logic o;
    io_write(BASE + 8'd1, 8'h01, 1);
    @(negedge cpu_clk); irq_in[0] = 1'b1;
    repeat (2) @(negedge cpu_clk); irq_in[0] = 1'b0;
    wait_int_low("midrst_int");
    @(negedge cpu_clk); m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge cpu_clk);
    vectors++;
    if (dout_oe !== 1'b1) begin miscompares++; $display("FAIL midrst_ack_oe: dout_oe=%b, required 1", dout_oe); end
    #1 reset_n = 1'b0;
    #1 vectors++;
    if (dout_oe !== 1'b0 || int_n !== 1'b1 || dout !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_outputs: oe=%b int_n=%b dout=%h, required 0/1/00", dout_oe, int_n, dout);
    end
    @(negedge cpu_clk); m1_n = 1'b1; iorq_n = 1'b1;
    @(negedge cpu_clk); reset_n = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      io_read(BASE + 8'(i), d, o);
      e = exp_q.pop_front(); vectors++;
      if (d !== e) begin miscompares++; $display("FAIL midrst_reg%0d: got %h, required %h", i, d, e); end
    end
  endtask

  initial begin
    reset_n = 1'b0; irq_in = '0;
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = '0; din = '0;
    test_reset();
    test_edge_latch();
    test_ack_priority();
    test_mask_collision();
    test_write_once();
    test_mode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_irq_ctrl.md
Name: z80_irq_ctrl

Overview:
- Z80 I/O-bus responder: latches asynchronous event inputs (e.g. VGA vsync, hsync) as pending interrupts and drives INT_n to the T80.
- Answers IM2 interrupt-acknowledge cycles with a vector byte and exposes status/enable/vector registers in I/O space.
- Sits beside the T80 in cpu_clk domain; its dout is muxed into the CPU din when dout_oe is high.

Parameters:
- NSRC, 4, number of interrupt sources (1..4); source 0 is highest priority.
- BASE, 8'h10, I/O base address; registers at BASE+0..BASE+3, decoded on addr[7:0].

Ports:
- cpu_clk  in  1  CPU clock (4 MHz); all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- irq_in  in  NSRC  raw event inputs, any clock domain.
- iorq_n  in  1  Z80 IORQ_n.
- m1_n  in  1  Z80 M1_n.
- rd_n  in  1  Z80 RD_n.
- wr_n  in  1  Z80 WR_n.
- addr  in  8  Z80 A[7:0].
- din  in  8  Z80 DO (write data).
- dout  out  8  read or vector data.
- dout_oe  out  1  high when dout must drive CPU din.
- int_n  out  1  to T80 INT_n.

Behaviour:
- Reset: pending=0, enable=0, vbase=8'h00, mode=0, sync flops=0, int_n=1, dout=0, dout_oe=0, ack state IDLE.
- Synchronisers: each irq_in bit goes through 2 flops, then a third flop for edge detect. A rising edge sets pending[i] 3 cycles after the input rises. Pulses shorter than one cpu_clk may be lost.
- int_n = ~|(pending & enable), registered. Asserts 1 cycle after pending/enable changes.
- I/O cycle definitions:
  - io_wr = !iorq_n & !wr_n & m1_n & addr hit.
  - io_rd = !iorq_n & !rd_n & m1_n & addr hit.
- Registers:
  - BASE+0 status: read = pending (upper bits 0); write = write-1-to-clear.
  - BASE+1 enable: R/W, bits [NSRC-1:0].
  - BASE+2 vbase: R/W, only bits [7:3] stored, [2:0] read 0.
  - BASE+3 mode: see Optional Feature.
- Write strobe: a register updates exactly once per I/O write. Rising edge of io_wr, takes effect on the next cycle; held strobe cycles are ignored.
- Reads: dout_oe = io_rd (combinational); dout = selected register. Unmapped addresses give dout_oe=0.
- Set/clear priority: an edge event on the same cycle as a W1C or ack clear of the same bit wins, so the bit stays 1.
- Ack FSM, cycle = !m1_n & !iorq_n:
  - IDLE -> ACK on first ack cycle: latch idx = lowest i with pending&enable set. If none is set, latch idx=0 and flag spurious.
  - In ACK: dout_oe=1, dout = {vbase[7:3], idx[1:0], 1'b0}.
  - ACK -> IDLE when iorq_n returns high: clear pending[idx] unless spurious; dout_oe falls the same cycle.
  - During ACK, bus writes/reads are ignored.
- Reset mid-cycle: async reset_n low returns everything to reset values immediately, including dropping dout_oe.

Optional Feature:
- IRQ_LEVEL_EN defined:
  - BASE+3 is a R/W mode register. mode[i]=1 makes source i level-sensitive: pending[i] mirrors the synchronised input (2-flop latency).
  - W1C and ack clear have no effect on level-mode bits.
- IRQ_LEVEL_EN undefined:
  - All sources are edge-only. BASE+3 reads 8'h00 with dout_oe=1; writes are ignored; no mode flops exist.

Test Plan:
- Reset check: hold reset_n low -> int_n=1, dout_oe=0. Release; I/O read BASE+0/+1/+2 -> 8'h00.
- Edge latch: write enable=8'h01; pulse irq_in[0] for 2 cycles -> status reads 8'h01, int_n=0 within 4 cycles. Write 8'h01 to BASE+0 -> int_n=1, status 8'h00.
- IM2 ack with priority: vbase=8'hA0, enable=8'h0F, raise irq_in[1] and irq_in[3].
  - First ack cycle -> dout=8'hA2, dout_oe=1; on ack end pending=8'h08.
  - Second ack -> dout=8'hA6; then int_n=1.
- Masking and collision:
  - irq_in[2] edge with enable=0 -> status 8'h04, int_n stays 1.
  - W1C of bit 2 on the same cycle as a new edge -> status remains 8'h04.
- Write-once: hold an I/O write of 8'h03 to BASE+1 for 3 cycles -> enable=8'h03, updated exactly once. Read of BASE+5 -> dout_oe=0.
- Level mode (IRQ_LEVEL_EN): mode=8'h01, hold irq_in[0] high -> W1C leaves status 8'h01. Drop input -> status 8'h00 within 3 cycles. Without the macro, BASE+3 reads 8'h00.
